// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: loader FSM states and default geometry.
package boot_loader_pkg;

    localparam int          DEF_ADDR_W    = 8;
    localparam int          DEF_DATA_W    = 8;
    localparam logic [7:0]  DEF_LOAD_BASE = 8'h00;
    localparam logic        RAM_RW_WRITE  = 1'b1;
    localparam logic        RAM_RW_READ   = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHK   = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERROR = 3'd5
    } loader_state_t;

endpackage

// File: rtl/boot_loader.sv
// Loads a length-prefixed, checksummed byte stream into RAM while holding the CPU,
// then hands the RAM port to the CPU (RUN) or parks with the CPU held (ERROR).
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] LOAD_BASE = ADDR_W'(DEF_LOAD_BASE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_data,
    input  logic              i_cpu_rw,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_data,
    output logic              o_ram_rw,
    output logic              o_cpu_hold,
    output logic              o_load_done,
    output logic              o_load_err
);

    loader_state_t     r_state;
    logic [DATA_W-1:0] r_len;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_sum;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_wr_pend;
    logic              r_in_ready;
    logic              r_cpu_hold;
    logic              r_load_done;
    logic              r_load_err;

    logic              w_xfer;
    logic              w_run;
    logic [ADDR_W-1:0] w_cnt_next;
    logic [DATA_W-1:0] w_chk_sum;

    assign w_xfer     = i_in_valid & r_in_ready;
    assign w_run      = (r_state == ST_RUN);
    assign w_cnt_next = r_cnt + 1'b1;
    assign w_chk_sum  = r_sum + i_in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_wr_pend   <= 1'b0;
            r_in_ready  <= 1'b0;
            r_cpu_hold  <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            // A write strobe lives for exactly one cycle unless a new byte re-arms it.
            r_wr_pend <= RAM_RW_READ;
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_LEN;
                    r_in_ready <= 1'b1;
                end
                ST_LEN: begin
                    if (w_xfer) begin
                        r_len   <= i_in_data;
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_xfer) begin
                        r_wr_pend <= RAM_RW_WRITE;
                        r_wr_addr <= LOAD_BASE + r_cnt;
                        r_wr_data <= i_in_data;
                        r_cnt     <= w_cnt_next;
                        r_sum     <= w_chk_sum;
                        // A length byte of 0 wraps to match after the 256th byte.
                        if (w_cnt_next == ADDR_W'(r_len)) begin
                            r_state <= ST_CHK;
                        end
                    end
                end
                ST_CHK: begin
                    if (w_xfer) begin
                        r_in_ready <= 1'b0;
                        if (w_chk_sum == '0) begin
                            r_state     <= ST_RUN;
                            r_cpu_hold  <= 1'b0;
                            r_load_done <= 1'b1;
                        end else begin
                            r_state    <= ST_ERROR;
                            r_load_err <= 1'b1;
                        end
                    end
                end
                ST_RUN, ST_ERROR: begin
                    r_in_ready <= 1'b0;
                end
                default: begin
                    r_state    <= ST_ERROR;
                    r_in_ready <= 1'b0;
                    r_cpu_hold <= 1'b1;
                    r_load_err <= 1'b1;
                end
            endcase
        end
    end

    // RAM port mux: CPU owns the port only in RUN.
    always_comb begin
        o_ram_addr = r_wr_addr;
        o_ram_data = r_wr_data;
        o_ram_rw   = r_wr_pend;
        if (w_run) begin
            o_ram_addr = i_cpu_addr;
            o_ram_data = i_cpu_data;
            o_ram_rw   = i_cpu_rw;
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_cpu_hold  = r_cpu_hold;
    assign o_load_done = r_load_done;
    assign o_load_err  = r_load_err;

endmodule

// File: tb/tb_boot_loader.sv
// Directed and randomized image loads checked against a stream-level model of the loader.
module tb_boot_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i_in_data = '0;
    logic       i_in_valid = 1'b0;
    logic       o_in_ready;
    logic [7:0] i_cpu_addr = '0;
    logic [7:0] i_cpu_data = '0;
    logic       i_cpu_rw = 1'b0;
    logic [7:0] o_ram_addr;
    logic [7:0] o_ram_data;
    logic       o_ram_rw;
    logic       o_cpu_hold;
    logic       o_load_done;
    logic       o_load_err;

    boot_loader dut (
        .clk         (clk),
        .rst         (rst),
        .i_in_data   (i_in_data),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_cpu_addr  (i_cpu_addr),
        .i_cpu_data  (i_cpu_data),
        .i_cpu_rw    (i_cpu_rw),
        .o_ram_addr  (o_ram_addr),
        .o_ram_data  (o_ram_data),
        .o_ram_rw    (o_ram_rw),
        .o_cpu_hold  (o_cpu_hold),
        .o_load_done (o_load_done),
        .o_load_err  (o_load_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  tb_mem [256];
    logic [15:0] wr_log [$];
    logic [7:0]  img [$];

    // Behaves like the attached RAM; loader writes are also logged in order.
    always @(negedge clk) begin
        if (!rst && o_ram_rw) begin
            tb_mem[o_ram_addr] = o_ram_data;
            if (o_cpu_hold) wr_log.push_back({o_ram_addr, o_ram_data});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_in_valid = 1'b0;
        i_in_data = '0;
        i_cpu_addr = '0;
        i_cpu_data = '0;
        i_cpu_rw = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", o_in_ready, 0);
        check("rst_cpu_hold", o_cpu_hold, 1);
        check("rst_load_done", o_load_done, 0);
        check("rst_load_err", o_load_err, 0);
        check("rst_ram_rw", o_ram_rw, 0);
        rst = 1'b0;
        #1 check("idle_in_ready", o_in_ready, 0);
        @(negedge clk);
        check("len_in_ready", o_in_ready, 1);
        wr_log.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        @(negedge clk);
        i_in_valid = 1'b1;
        i_in_data = b;
        while (!o_in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("handshake_ready", o_in_ready, 1);
        @(posedge clk);
        #1 i_in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Load img[] with the given length byte and checksum, then compare against the model.
    task automatic run_image(input string name, input logic [7:0] len_b, input logic [7:0] chk,
                             input int gap);
        int         total;
        logic       exp_ok;
        logic [15:0] got;
        do_reset();
        send_byte(len_b, 0);
        foreach (img[i]) send_byte(img[i], gap);
        send_byte(chk, 0);
        repeat (3) @(negedge clk);
        total = int'(chk);
        foreach (img[i]) total += int'(img[i]);
        exp_ok = ((total % 256) == 0);
        check({name, "_load_done"}, o_load_done, exp_ok);
        check({name, "_load_err"}, o_load_err, !exp_ok);
        check({name, "_cpu_hold"}, o_cpu_hold, !exp_ok);
        check({name, "_in_ready"}, o_in_ready, 0);
        check({name, "_ram_rw"}, o_ram_rw, 0);
        check({name, "_n_writes"}, wr_log.size(), img.size());
        foreach (img[i]) begin
            got = (i < wr_log.size()) ? wr_log[i] : 16'hxxxx;
            check($sformatf("%s_wr%0d", name, i), got, {8'(i), img[i]});
            check($sformatf("%s_mem%0d", name, i), tb_mem[i % 256], img[i]);
        end
        $display("image %s: len=%0d chk=%02h gap=%0d", name, img.size(), chk, gap);
    endtask

    initial begin
        logic [7:0] s;
        int n;

        // 1: basic good image
        img = '{8'h10, 8'h20, 8'h30};
        run_image("good3", 8'h03, 8'hA0, 0);

        // 6: CPU pass-through in RUN; extra stream bytes refused
        @(negedge clk);
        #2;
        i_cpu_addr = 8'h40;
        i_cpu_data = 8'h7E;
        i_cpu_rw = 1'b1;
        #1;
        check("run_ram_addr", o_ram_addr, 8'h40);
        check("run_ram_data", o_ram_data, 8'h7E);
        check("run_ram_rw", o_ram_rw, 1);
        @(negedge clk);
        i_cpu_rw = 1'b0;
        #1 check("run_ram_rw_off", o_ram_rw, 0);
        i_in_valid = 1'b1;
        i_in_data = 8'h99;
        repeat (3) @(negedge clk);
        check("run_extra_ready", o_in_ready, 0);
        check("run_extra_done", o_load_done, 1);
        check("run_extra_nwr", wr_log.size(), 3);
        i_in_valid = 1'b0;

        // 2: bad checksum parks in ERROR
        img = '{8'h01, 8'h02};
        run_image("badchk", 8'h02, 8'h00, 0);

        // 3: length 0 means 256, fills all of RAM
        img.delete();
        for (int i = 0; i < 256; i++) img.push_back(8'(i));
        run_image("full256", 8'h00, 8'h80, 0);

        // 4: stalls between data bytes
        img = '{8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h11};
        s = 8'h00;
        foreach (img[i]) s += img[i];
        run_image("gaps", 8'h05, 8'(-s), 3);

        // 5: reset mid-load, then a fresh image
        do_reset();
        send_byte(8'h04, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_cpu_hold", o_cpu_hold, 1);
        check("midrst_in_ready", o_in_ready, 0);
        check("midrst_ram_rw", o_ram_rw, 0);
        check("midrst_load_done", o_load_done, 0);
        img = '{8'h55};
        run_image("fresh", 8'h01, 8'hAB, 0);

        // Randomized images, alternating valid and corrupted checksums
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 24);
            img.delete();
            s = 8'h00;
            for (int i = 0; i < n; i++) begin
                img.push_back(8'($urandom));
                s += img[i];
            end
            s = 8'(-s);
            if (t % 2 == 1) s = s + 8'($urandom_range(1, 255));
            run_image($sformatf("rand%0d", t), 8'(n), s, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
